// File: rtl/npu_out_pkg.sv
// npu_out_packer shared definitions.
// Default geometry, derived widths and keep-mask helper.
package npu_out_pkg;

  localparam int DEF_PACK  = 4;
  localparam int DEF_DEPTH = 8;
  localparam int LANE_W    = $clog2(DEF_PACK);
  localparam int PTR_W     = $clog2(DEF_DEPTH);

  // LSB-contiguous mask of n ones; n may equal 8.
  function automatic logic [7:0] keep_of(input logic [3:0] n);
    logic [8:0] m;
    m = (9'd1 << n) - 9'd1;
    return m[7:0];
  endfunction

endpackage

// File: rtl/npu_out_if.sv
// Packed-word stream toward the host/DMA side.
// Head word, keep mask and valid/ready handshake.
interface npu_out_if #(
  parameter int PACK = npu_out_pkg::DEF_PACK
) ();

  logic [8*PACK-1:0] data;
  logic [PACK-1:0]   keep;
  logic              valid;
  logic              ready;

  modport master (
    output data,
    output keep,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  keep,
    input  valid,
    output ready
  );

endinterface

// File: rtl/npu_out_fifo.sv
// Synchronous first-word-fall-through FIFO.
// A pop frees the slot for a push in the same edge.
module npu_out_fifo
  import npu_out_pkg::*;
#(
  parameter int DATA_W = 36,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr;
  logic [AW:0]       rd;
  logic              do_push;
  logic              do_pop;

  assign empty   = (wr == rd);
  assign full    = (wr[AW] != rd[AW]) &&
                   (wr[AW-1:0] == rd[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (do_push) wr <= wr + (AW+1)'(1);
      if (do_pop)  rd <= rd + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/npu_out_packer.sv
// Packs the NPU result byte stream into words.
// Non-stallable input: a drop on a full FIFO sets a sticky flag.
module npu_out_packer
  import npu_out_pkg::*;
#(
  parameter int PACK  = DEF_PACK,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_data,
  input  logic             in_en,
  input  logic             flush,
  input  logic             clr_ovf,
  npu_out_if.master        m,
  output logic             overflow,
  output logic [CNT_W-1:0] byte_cnt
);

  localparam int LW = $clog2(PACK);
  localparam int DW = 8*PACK + PACK;

  logic [LW-1:0]         lane;
  logic [PACK-1:0][7:0]  asm_q;
  logic [PACK-1:0][7:0]  word;
  logic [LW:0]           n;
  logic [7:0]            kmask;
  logic [PACK-1:0]       keep;
  logic                  full_push;
  logic                  flush_push;
  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DW-1:0]         rdata;

  // n counts the byte accepted in this same cycle.
  always_comb begin
    word = asm_q;
    if (in_en) word[lane] = in_data;
    n          = {1'b0, lane} + (LW+1)'(in_en);
    full_push  = in_en && (lane == LW'(PACK-1));
    flush_push = flush && (n != '0);
    push       = full_push || flush_push;
    kmask      = keep_of(4'(n));
    keep       = full_push ? '1 : kmask[PACK-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane  <= '0;
      asm_q <= '0;
    end else if (push) begin
      lane  <= '0;
      asm_q <= '0;
    end else if (in_en) begin
      lane  <= lane + LW'(1);
      asm_q <= word;
    end
  end

  assign pop = m.valid && m.ready;

  // A same-cycle drop beats the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      byte_cnt <= '0;
    end else begin
      if (push && fifo_full && !pop) overflow <= 1'b1;
      else if (clr_ovf)              overflow <= 1'b0;
      byte_cnt <= byte_cnt + CNT_W'(in_en);
    end
  end

  npu_out_fifo #(
    .DATA_W (DW),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata ({keep, word}),
    .pop   (pop),
    .rdata (rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign m.valid = !fifo_empty;
  assign m.data  = rdata[8*PACK-1:0];
  assign m.keep  = rdata[DW-1:8*PACK];

endmodule

// File: doc/npu_out_packer.md
Name: npu_out_packer

Overview:
- Sits directly downstream of the NPU top level and consumes its 8-bit result stream (`out`/`out_en`) from the arithmetic part.
- Packs consecutive result bytes into PACK-byte words and buffers them in a small synchronous FIFO.
- Presents the words to the host/DMA side over a valid/ready handshake.
- The NPU stream cannot be stalled, so loss of data on overflow is flagged rather than prevented.

Parameters:
- PACK, 4, result bytes per output word (power of two, 2..8).
- DEPTH, 8, FIFO depth in words (power of two, ≥2).
- CNT_W, 16, width of the accepted-byte counter.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- in_data  input  8  result byte from the NPU (`out`).
- in_en  input  1  in_data valid this cycle (`out_en`); no backpressure.
- flush  input  1  one-cycle pulse: push the partially filled word now.
- clr_ovf  input  1  clears the sticky overflow flag.
- m_data  output  8*PACK  word at the FIFO head; byte 0 in bits [7:0].
- m_keep  output  PACK  valid-byte mask of the head word, LSB-contiguous.
- m_valid  output  1  FIFO not empty.
- m_ready  input  1  consumer accepts the word when m_valid && m_ready.
- overflow  output  1  sticky: a word was dropped because the FIFO was full.
- byte_cnt  output  CNT_W  bytes accepted since reset; wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous, active-high):
  - lane=0, assembly register=0, FIFO empty.
  - m_valid=0, m_data=0, m_keep=0, overflow=0, byte_cnt=0.
  - Asserting reset mid-word or mid-FIFO discards all content.
- Byte assembly:
  - lane counter 0..PACK-1.
  - When in_en=1: in_data is written into byte `lane` of the assembly register, lane increments, and byte_cnt increments.
- Full word:
  - When in_en=1 and lane==PACK-1, the completed word (including the current byte) is pushed with keep all ones in the same edge.
  - lane returns to 0 and the assembly register clears.
- Flush (flush=1):
  - Let n = lane + in_en, counting the byte accepted in the same cycle.
  - If 0 < n < PACK: push the assembly word zero-padded, with keep = (1<<n)-1; lane→0.
  - If n==PACK: normal full push; flush adds nothing.
  - If n==0: no push, no effect.
- Push timing: a pushed word is visible as m_valid=1 on the cycle after the push edge (1-cycle latency from the last byte).
- Pop: m_valid && m_ready pops at the edge. m_data and m_keep always show the FIFO head and are zero when empty.
- Simultaneous push and pop:
  - Always allowed, including when the FIFO is full; the pop frees the slot for the push in the same edge.
  - Occupancy is unchanged.
- Full without pop:
  - The pushed word is dropped, overflow is set to 1, and FIFO contents are unchanged.
  - lane still resets, so following bytes start a fresh word.
- clr_ovf:
  - Clears overflow on the next edge.
  - If a drop occurs in the same cycle, the set wins and overflow stays 1.
- byte_cnt counts every in_en byte, including bytes lost in dropped words.
- Occupancy tracking:
  - Read/write pointers of log2(DEPTH) bits plus one wrap bit.
  - full = pointers equal except the wrap bit; empty = pointers fully equal.
- m_valid is a registered function of occupancy, with no combinational path from in_en. m_ready affects state only and reaches no output combinationally.

Decomposition:
- Shared package npu_out_pkg:
  - PACK and DEPTH defaults.
  - Derived widths LANE_W=$clog2(PACK) and PTR_W=$clog2(DEPTH).
  - Keep-mask function keep_of(n).
- Sub-module npu_out_fifo(DATA_W=8*PACK+PACK, DEPTH):
  - Synchronous FIFO with push/pop/full/empty; first-word-fall-through head output.
  - Asynchronous active-high reset on clk/reset.
- The packer top holds the lane counter, assembly register, flush logic, overflow flag and byte counter.

Test Plan:
- Stream pack: send 8 bytes with in_en=1 (0x01..0x08), m_ready=1 → two words 0x04030201 then 0x08070605, keep=4'hF, byte_cnt=8, overflow=0.
- Flush partial: send 0xAA, 0xBB, then flush alone → one word 0x0000BBAA, keep=4'h3; a following flush with nothing pending produces no word.
- Flush with same-cycle byte: send 0x11, 0x22, 0x33 with flush asserted on the 0x33 cycle → word 0x00332211, keep=4'h7, lane=0 afterwards.
- Full FIFO drop: m_ready=0, send 36 bytes → FIFO holds the first 8 words and overflow=1. Drain → exactly 8 words, last = bytes 29..32. clr_ovf → overflow=0.
- Push+pop at full: fill 8 words, then hold m_ready=1 while a 9th word completes → no overflow, and the 9th word arrives in order after the first 8.
- Async reset mid-operation: reset asserted between clock edges with 3 words queued and lane=2 → m_valid=0, byte_cnt=0, overflow=0 immediately. The next 4 bytes form a clean word with keep=4'hF.
